// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master round-robin arbiter and sequencer for the shared
// device bus behind the CPU data port. One master owns the bus at a time. The
// owner's address is decoded into one of four device windows, and the arbiter
// waits for that device's ready signal. It then returns read data, or it
// reports an error on a decode miss, a misaligned address or a timeout.
// Every output comes straight from a flop.

module sys_bus_arbiter #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [31:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic          m0_err,
   output logic [31:0]   m0_rdata,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic          m1_err,
   output logic [31:0]   m1_rdata,

   output logic [3:0]    dev_sel,
   output logic          dev_we,
   output logic [31:0]   dev_addr,
   output logic [31:0]   dev_wdata,
   input  logic [127:0]  dev_rdata,
   input  logic [3:0]    dev_ready
);

   // MISS is a one-cycle holding state for decode failures. It keeps the
   // grant pulse and the error completion in separate cycles.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_MISS,
      ST_RESP,
      ST_ERR
   } state_t;

   // The wait counter holds this value in the last ACCESS cycle before a timeout.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              m0_gnt_q, m0_gnt_d;
   logic              m1_gnt_q, m1_gnt_d;
   logic              m0_done_q, m0_done_d;
   logic              m1_done_q, m1_done_d;
   logic              m0_err_q, m0_err_d;
   logic              m1_err_q, m1_err_d;
   logic [31:0]       m0_rdata_q, m0_rdata_d;
   logic [31:0]       m1_rdata_q, m1_rdata_d;

   logic [3:0]        dev_sel_q, dev_sel_d;
   logic              dev_we_q, dev_we_d;
   logic [31:0]       dev_addr_q, dev_addr_d;
   logic [31:0]       dev_wdata_q, dev_wdata_d;

   logic              any_req;
   logic              win_m1;
   logic              win_we;
   logic [31:0]       win_addr;
   logic [31:0]       win_wdata;
   logic [3:0]        hit_sel;
   logic              decode_ok;

   logic              sel_ready;
   logic [31:0]       sel_rdata;
   logic [31:0]       resp_rdata;

   // Round-robin pick of the requesting master and window decode of its address.
   always_comb begin
      any_req   = m0_req | m1_req;
      win_m1    = m1_req & (~m0_req | ~last_q);
      win_we    = win_m1 ? m1_we    : m0_we;
      win_addr  = win_m1 ? m1_addr  : m0_addr;
      win_wdata = win_m1 ? m1_wdata : m0_wdata;

      hit_sel[0] = (win_addr[31:4] == 28'h00007F0) && (win_addr[3:0] <= 4'hB);
      hit_sel[1] = (win_addr[31:4] == 28'h00007F1) && (win_addr[3:0] <= 4'hB);
      hit_sel[2] = (win_addr[31:4] == 28'h00007F2);
      hit_sel[3] = (win_addr[31:4] == 28'h00007F3);

      decode_ok = (win_addr[1:0] == 2'b00) && (|hit_sel);
   end

   // Only the selected device's ready and read data are visible to the sequencer.
   always_comb begin
      sel_ready = |(dev_ready & dev_sel_q);
      sel_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (dev_sel_q[i]) begin
            sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
         end
      end
      resp_rdata = dev_we_q ? 32'h0 : sel_rdata;
   end

   // Sequencer next-state logic. Pulse outputs default to zero. The bus drive
   // registers hold their value unless a transaction starts or ends.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;

      m0_gnt_d    = 1'b0;
      m1_gnt_d    = 1'b0;
      m0_done_d   = 1'b0;
      m1_done_d   = 1'b0;
      m0_err_d    = 1'b0;
      m1_err_d    = 1'b0;
      m0_rdata_d  = 32'h0;
      m1_rdata_d  = 32'h0;

      dev_sel_d   = dev_sel_q;
      dev_we_d    = dev_we_q;
      dev_addr_d  = dev_addr_q;
      dev_wdata_d = dev_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d  = win_m1;
               last_d   = win_m1;
               m0_gnt_d = ~win_m1;
               m1_gnt_d = win_m1;
               cnt_d    = '0;
               if (decode_ok) begin
                  state_d     = ST_ACCESS;
                  dev_sel_d   = hit_sel;
                  dev_we_d    = win_we;
                  dev_addr_d  = {win_addr[31:2], 2'b00};
                  dev_wdata_d = win_wdata;
               end else begin
                  state_d = ST_MISS;
               end
            end
         end

         ST_ACCESS: begin
            if (sel_ready) begin
               state_d    = ST_RESP;
               m0_done_d  = ~owner_q;
               m1_done_d  = owner_q;
               m0_rdata_d = owner_q ? 32'h0 : resp_rdata;
               m1_rdata_d = owner_q ? resp_rdata : 32'h0;
               dev_sel_d  = 4'b0000;
               dev_we_d   = 1'b0;
               cnt_d      = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ST_ERR;
               m0_done_d = ~owner_q;
               m1_done_d = owner_q;
               m0_err_d  = ~owner_q;
               m1_err_d  = owner_q;
               dev_sel_d = 4'b0000;
               dev_we_d  = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_MISS: begin
            state_d   = ST_ERR;
            m0_done_d = ~owner_q;
            m1_done_d = owner_q;
            m0_err_d  = ~owner_q;
            m1_err_d  = owner_q;
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         ST_ERR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, bookkeeping and output registers. Reset abandons any transaction
   // in flight without a completion pulse. The last-grant pointer resets to
   // master 1, so master 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_done_q   <= 1'b0;
         m1_done_q   <= 1'b0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
         m0_rdata_q  <= 32'h0;
         m1_rdata_q  <= 32'h0;
         dev_sel_q   <= 4'b0000;
         dev_we_q    <= 1'b0;
         dev_addr_q  <= 32'h0;
         dev_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         m0_gnt_q    <= m0_gnt_d;
         m1_gnt_q    <= m1_gnt_d;
         m0_done_q   <= m0_done_d;
         m1_done_q   <= m1_done_d;
         m0_err_q    <= m0_err_d;
         m1_err_q    <= m1_err_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
         dev_sel_q   <= dev_sel_d;
         dev_we_q    <= dev_we_d;
         dev_addr_q  <= dev_addr_d;
         dev_wdata_q <= dev_wdata_d;
      end
   end

   assign m0_gnt    = m0_gnt_q;
   assign m1_gnt    = m1_gnt_q;
   assign m0_done   = m0_done_q;
   assign m1_done   = m1_done_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign dev_sel   = dev_sel_q;
   assign dev_we    = dev_we_q;
   assign dev_addr  = dev_addr_q;
   assign dev_wdata = dev_wdata_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Testbench for sys_bus_arbiter. It runs directed scenarios and then
// randomized transactions. A transaction-level model inside the bench predicts
// the grant order, the device window, the completion cycle and the returned
// data.

module tb_sys_bus_arbiter;

   localparam int TIMEOUT_CYC = 16;
   localparam int CNT_W       = 5;

   logic          clk;
   logic          reset;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic          m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [3:0]    dev_sel;
   logic          dev_we;
   logic [31:0]   dev_addr, dev_wdata;
   logic [127:0]  dev_rdata;
   logic [3:0]    dev_ready;

   int tests = 0;
   int fails = 0;
   int lastGrant;

   logic [31:0] addrPool [16] = '{
      32'h00007F00, 32'h00007F04, 32'h00007F08, 32'h00007F0B,
      32'h00007F0C, 32'h00007F10, 32'h00007F18, 32'h00007F1C,
      32'h00007F20, 32'h00007F2C, 32'h00007F30, 32'h00007F3C,
      32'h00007F40, 32'h00007EFC, 32'h00017F20, 32'h00007F12
   };

   sys_bus_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .dev_rdata(dev_rdata), .dev_ready(dev_ready)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run goes badly astray.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Maps an address to the index of its device window, or -1 if it hits no window.
   function automatic int winOf(input logic [31:0] a);
      if (a >= 32'h7F00 && a <= 32'h7F0B) return 0;
      if (a >= 32'h7F10 && a <= 32'h7F1B) return 1;
      if (a >= 32'h7F20 && a <= 32'h7F2F) return 2;
      if (a >= 32'h7F30 && a <= 32'h7F3F) return 3;
      return -1;
   endfunction

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      if (m == 0) begin
         m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   // Runs one arbitration round. Requests are already on the pins and the DUT
   // is idle. The target device raises ready 'delay' cycles after it is
   // selected, and a delay of TIMEOUT_CYC or more means it never answers.
   task automatic runTxn(input int delay, input string tag);
      int           w, win, doneOff;
      bit           derr, tmo;
      logic         wr;
      logic [31:0]  a, wd, expRd;
      logic [3:0]   sel, noise;
      logic [127:0] rd;
      logic [1:0]   pair;

      if (m0_req && m1_req) w = (lastGrant == 1) ? 0 : 1;
      else if (m0_req)      w = 0;
      else                  w = 1;
      lastGrant = w;

      a    = (w == 0) ? m0_addr  : m1_addr;
      wr   = (w == 0) ? m0_we    : m1_we;
      wd   = (w == 0) ? m0_wdata : m1_wdata;
      win  = winOf(a);
      derr = (a[1:0] != 2'b00) || (win < 0);
      tmo  = !derr && (delay >= TIMEOUT_CYC);
      sel  = derr ? 4'b0000 : (4'b0001 << win);
      pair = (w == 0) ? 2'b10 : 2'b01;

      rd        = {$urandom, $urandom, $urandom, $urandom};
      dev_rdata = rd;
      if (tag == "plan_read") begin
         rd[31:0]  = 32'hDEADBEEF;
         dev_rdata = rd;
      end
      expRd = 32'h0;
      if (!derr && !tmo && !wr) expRd = rd[32*win +: 32];

      if (derr)     doneOff = 2;
      else if (tmo) doneOff = 1 + TIMEOUT_CYC;
      else          doneOff = 2 + delay;

      noise     = 4'($urandom) & ~sel;
      dev_ready = noise;

      for (int k = 1; k <= doneOff; k++) begin
         stepCycle;
         noise     = 4'($urandom) & ~sel;
         dev_ready = noise | ((!derr && k == 1 + delay) ? sel : 4'b0000);

         checkOutput({tag, ".gnt"}, {30'h0, m0_gnt, m1_gnt}, (k == 1) ? {30'h0, pair} : 32'h0);
         checkOutput({tag, ".sel"}, {28'h0, dev_sel},
                     (!derr && k < doneOff) ? {28'h0, sel} : 32'h0);
         if (!derr && k < doneOff) begin
            checkOutput({tag, ".addr"}, dev_addr, {a[31:2], 2'b00});
            checkOutput({tag, ".wdata"}, dev_wdata, wd);
            checkOutput({tag, ".we"}, {31'h0, dev_we}, {31'h0, wr});
         end
         checkOutput({tag, ".done"}, {30'h0, m0_done, m1_done},
                     (k == doneOff) ? {30'h0, pair} : 32'h0);
         checkOutput({tag, ".err"}, {30'h0, m0_err, m1_err},
                     (k == doneOff && (derr || tmo)) ? {30'h0, pair} : 32'h0);
         if (k == doneOff) begin
            checkOutput({tag, ".rdata"}, (w == 0) ? m0_rdata : m1_rdata, expRd);
            if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
         end
      end

      stepCycle;
      dev_ready = 4'b0000;
      checkOutput({tag, ".idle"}, {24'h0, dev_sel, m0_done, m1_done, m0_gnt, m1_gnt}, 32'h0);
   endtask

   initial begin
      reset = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
      dev_rdata = '0; dev_ready = 4'b0000;
      lastGrant = 1;

      #1 reset = 1'b1;
      #1;
      checkOutput("reset.pulses", {26'h0, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err}, 32'h0);
      checkOutput("reset.sel", {27'h0, dev_we, dev_sel}, 32'h0);
      checkOutput("reset.addr", dev_addr, 32'h0);
      checkOutput("reset.wdata", dev_wdata, 32'h0);
      checkOutput("reset.rdata", m0_rdata | m1_rdata, 32'h0);
      stepCycle;
      stepCycle;
      reset = 1'b0;
      stepCycle;

      // Three back-to-back ties alternate m0, m1, m0. m1's held request then drains.
      applyStimulus(0, 1'b0, 32'h7F08, 32'h0);
      applyStimulus(1, 1'b1, 32'h7F14, 32'hA5A5_0001);
      runTxn(0, "rr1");
      applyStimulus(0, 1'b1, 32'h7F38, 32'hA5A5_0002);
      runTxn(1, "rr2");
      applyStimulus(1, 1'b0, 32'h7F2C, 32'h0);
      runTxn(2, "rr3");
      runTxn(0, "rr4");

      // m0 reads 0x7F04 and device 0 answers at once.
      applyStimulus(0, 1'b0, 32'h7F04, 32'h0);
      runTxn(0, "plan_read");

      // m1 writes 0x7F24 and device 2 takes five extra cycles.
      applyStimulus(1, 1'b1, 32'h7F24, 32'h1234_5678);
      runTxn(5, "slow_write");

      // The hole and the misaligned address both fail decode.
      applyStimulus(0, 1'b0, 32'h7F0C, 32'h0);
      runTxn(0, "hole");
      applyStimulus(0, 1'b0, 32'h7F12, 32'h0);
      runTxn(0, "misalign");

      // Device 3 never answers the write to 0x7F30.
      applyStimulus(0, 1'b1, 32'h7F30, 32'hCAFE_F00D);
      runTxn(99, "timeout");

      // Randomized traffic with the window edges, holes and misaligned addresses.
      for (int n = 0; n < 40; n++) begin
         if (!m0_req && $urandom_range(0, 1) == 1)
            applyStimulus(0, 1'($urandom), addrPool[$urandom_range(0, 15)], $urandom);
         if (!m1_req && $urandom_range(0, 1) == 1)
            applyStimulus(1, 1'($urandom), addrPool[$urandom_range(0, 15)], $urandom);
         if (!m0_req && !m1_req)
            applyStimulus($urandom_range(0, 1), 1'($urandom), addrPool[$urandom_range(0, 15)], $urandom);
         runTxn($urandom_range(0, 18), "rand");
      end
      for (int n = 0; n < 2; n++) begin
         if (m0_req || m1_req) runTxn(0, "drain");
      end

      // Reset lands while m1 waits in ACCESS.
      applyStimulus(1, 1'b0, 32'h7F20, 32'h0);
      dev_ready = 4'b0000;
      stepCycle;
      checkOutput("abort.gnt", {31'h0, m1_gnt}, 32'h1);
      stepCycle;
      stepCycle;
      checkOutput("abort.sel_before", {28'h0, dev_sel}, 32'h4);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort.sel_async", {28'h0, dev_sel}, 32'h0);
      checkOutput("abort.pulses_async", {28'h0, m0_gnt, m1_gnt, m0_done, m1_done}, 32'h0);
      m1_req = 1'b0;
      for (int n = 0; n < 3; n++) begin
         stepCycle;
         checkOutput("abort.held", {26'h0, dev_sel, m0_done, m1_done}, 32'h0);
      end
      reset = 1'b0;
      lastGrant = 1;
      for (int n = 0; n < 3; n++) begin
         stepCycle;
         checkOutput("abort.no_done", {26'h0, dev_sel, m0_done, m1_done}, 32'h0);
      end
      applyStimulus(0, 1'b0, 32'h7F18, 32'h0);
      applyStimulus(1, 1'b1, 32'h7F3C, 32'h5555_AAAA);
      runTxn(1, "post_reset_tie");
      runTxn(0, "post_reset_m1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared device bus behind the CPU data port.
- Master 0 is the CPU M-stage load/store path. Its requests are already filtered for AdEL/AdES. Master 1 is an auxiliary master (debug/DMA).
- Grants one master at a time, decodes the four device windows and drives a one-hot device select. Waits for device ready, returns read data, and reports a bus error on decode miss, misalignment or timeout.

Parameters:
- TIMEOUT_CYC, 16: cycles in ACCESS without dev_ready before the transaction aborts with an error.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request. Held until m0_done.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_gnt  out  1  one-cycle pulse when master 0's request is latched.
- m0_done  out  1  one-cycle completion pulse for master 0.
- m0_err  out  1  valid with m0_done: the transaction failed.
- m0_rdata  out  32  read data for master 0. Valid with m0_done when m0_err=0 and it was a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_err, m1_rdata: same as master 0, for master 1.
- dev_sel  out  4  one-hot device select. Bit i selects window i.
- dev_we  out  1  device write enable. Qualified by dev_sel.
- dev_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- dev_wdata  out  32  device write data.
- dev_rdata  in  128  device read data. Device i drives bits [32i+31:32i].
- dev_ready  in  4  device i ready. Sampled only while dev_sel[i]=1.

Behaviour:
- Device windows, inclusive:
  - Dev0 0x7F00-0x7F0B
  - Dev1 0x7F10-0x7F1B
  - Dev2 0x7F20-0x7F2F
  - Dev3 0x7F30-0x7F3F
- Reset: state=IDLE. All outputs 0. Wait counter 0. Last-grant pointer=1, so master 0 wins the first tie.
- All outputs are registered.
- IDLE:
  - One request: that master wins.
  - Both requests in the same cycle: the master not granted last wins (round-robin).
  - Winner's we, addr and wdata are latched. Last-grant pointer is updated.
- IDLE transitions:
  - addr[1:0]!=0 or no window hit -> ERR.
  - Otherwise -> ACCESS.
  - The winner's gnt pulses in the cycle after the request is sampled.
- ACCESS:
  - dev_sel, dev_we, dev_addr and dev_wdata are held stable.
  - Wait counter increments every cycle.
  - dev_ready[sel]=1: capture that device's rdata slice -> RESP.
  - Counter reaches TIMEOUT_CYC-1 without ready -> ERR.
  - dev_sel drops in the cycle after leaving ACCESS.
- RESP: owner's done=1, err=0, rdata valid (0 for writes) -> IDLE.
- ERR: owner's done=1, err=1, rdata=0 -> IDLE.
- Latency, request sampled at cycle T:
  - gnt and dev_sel at T+1.
  - Ready at T+1 gives done at T+2.
  - Next grant no earlier than T+3.
  - Decode error: done/err at T+2, dev_sel never asserted.
  - Timeout: done/err at T+1+TIMEOUT_CYC.
- Requests are not re-sampled outside IDLE. A master dropping req mid-transaction does not abort it; done is still pulsed.
- dev_ready on unselected devices is ignored.
- Reset mid-transaction: immediate return to IDLE. dev_sel, done and gnt clear asynchronously. No done is issued for the aborted transaction.
- Only one of m0_done and m1_done may be high in any cycle. gnt and done are never high in the same cycle for the same master.

Test Plan:
- m0 read 0x7F04, dev_ready[0] high immediately, dev_rdata[31:0]=0xDEADBEEF -> m0_gnt at T+1, dev_sel=0001, m0_done at T+2 with m0_rdata=0xDEADBEEF, m0_err=0.
- m0 and m1 request simultaneously, three times back-to-back -> grants alternate m0, m1, m0. Each dev_sel matches its own window.
- m1 write 0x7F24, data 0x12345678, dev_ready[2] delayed 5 cycles -> dev_sel=0100 and dev_wdata held stable for 6 cycles. m1_done one cycle after ready; m1_rdata=0.
- m0 read 0x7F0C (hole) and m0 read 0x7F12 (misaligned) -> each gives m0_done=1, m0_err=1 two cycles after sampling; dev_sel stays 0000.
- m0 write 0x7F30, dev_ready never asserted -> m0_err=1 with m0_done at T+17 (TIMEOUT_CYC=16), then dev_sel=0000.
- Assert reset during a wait in ACCESS -> dev_sel=0000 and no done pulse. After release, m0 wins a simultaneous request.
